clock_mode_ctrl: RTL and testbench

Timekeeping and mode controller for the digital clock. It consumes the one-cycle 1 Hz `enb` tick from `get1hz` and advances an hh:mm:ss register set in 24-hour format. It also runs a three-state set-time FSM driven by debounced push-button pulses. Its outputs feed the display/BCD decode stage directly.

---
 rtl/clock_mode_ctrl_pkg.sv | 18 +
 rtl/mod_counter.sv | 32 +++
 rtl/clock_mode_ctrl.sv | 124 ++++++++++++
 tb/tb_clock_mode_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_mode_ctrl_pkg.sv
// Shared definitions for the clock timekeeping/mode controller: mode encodings,
// field limits and field widths.
package clock_mode_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_e;

  localparam int unsigned HOUR_MAX    = 23;
  localparam int unsigned MIN_SEC_MAX = 59;

  localparam int unsigned HOUR_W    = 5;
  localparam int unsigned MIN_SEC_W = 6;
  localparam int unsigned MODE_W    = 2;

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) up counter with reset load value, synchronous clear and a
// wrap strobe used to chain counters into a carry ripple within one edge.
module mod_counter #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned MAX   = 59
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic at_max;

  assign at_max = (count == WIDTH'(MAX));
  assign wrap   = inc && at_max;

  // Clear has priority over increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= load_val;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= at_max ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/clock_mode_ctrl.sv
// 24-hour hh:mm:ss timekeeper with a RUN / SET_HOUR / SET_MIN edit FSM driven by
// debounced button pulses and the 1 Hz tick.
module clock_mode_ctrl
  import clock_mode_ctrl_pkg::*;
#(
  parameter int unsigned INIT_HOUR = 0,
  parameter int unsigned INIT_MIN  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enb,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [1:0] mode,
  output logic       blink
);

  mode_e state_q;

  logic in_run;
  logic in_set_hour;
  logic in_set_min;
  logic edit_inc;
  logic sec_inc;
  logic sec_clr;
  logic min_inc;
  logic hour_inc;
  logic sec_wrap;
  logic min_wrap;
  logic hour_wrap_unused;

  assign in_run      = (state_q == MODE_RUN);
  assign in_set_hour = (state_q == MODE_SET_HOUR);
  assign in_set_min  = (state_q == MODE_SET_MIN);

  // A mode press in the same cycle swallows the increment.
  assign edit_inc = btn_inc && !btn_mode;

  // Carries only ripple while running; edits never carry into the other field.
  assign sec_inc  = in_run && enb;
  assign sec_clr  = in_set_min && btn_mode;
  assign min_inc  = (in_run && sec_wrap) || (in_set_min && edit_inc);
  assign hour_inc = (in_run && min_wrap) || (in_set_hour && edit_inc);

  mod_counter #(
    .WIDTH (MIN_SEC_W),
    .MAX   (MIN_SEC_MAX)
  ) u_sec (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_val ('0),
    .inc      (sec_inc),
    .clr      (sec_clr),
    .count    (second),
    .wrap     (sec_wrap)
  );

  mod_counter #(
    .WIDTH (MIN_SEC_W),
    .MAX   (MIN_SEC_MAX)
  ) u_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_val (MIN_SEC_W'(INIT_MIN)),
    .inc      (min_inc),
    .clr      (1'b0),
    .count    (minute),
    .wrap     (min_wrap)
  );

  mod_counter #(
    .WIDTH (HOUR_W),
    .MAX   (HOUR_MAX)
  ) u_hour (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_val (HOUR_W'(INIT_HOUR)),
    .inc      (hour_inc),
    .clr      (1'b0),
    .count    (hour),
    .wrap     (hour_wrap_unused)
  );

  // Mode FSM and blink phase; blink only toggles on ticks while editing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MODE_RUN;
      blink   <= 1'b0;
    end else begin
      case (state_q)
        MODE_RUN: begin
          if (btn_mode) begin
            state_q <= MODE_SET_HOUR;
            blink   <= 1'b1;
          end else begin
            blink <= 1'b0;
          end
        end
        MODE_SET_HOUR: begin
          if (btn_mode) state_q <= MODE_SET_MIN;
          if (enb) blink <= ~blink;
        end
        MODE_SET_MIN: begin
          if (btn_mode) begin
            state_q <= MODE_RUN;
            blink   <= 1'b0;
          end else if (enb) begin
            blink <= ~blink;
          end
        end
        default: begin
          state_q <= MODE_RUN;
          blink   <= 1'b0;
        end
      endcase
    end
  end

  assign mode = MODE_W'(state_q);

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Self-checking bench for clock_mode_ctrl: a seconds-of-day reference model checked
// every cycle, plus directed scenarios with literal expected times.
module tb_clock_mode_ctrl;

  localparam int INIT_H = 23;
  localparam int INIT_M = 59;

  logic       clk;
  logic       rst_n;
  logic       enb;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [1:0] mode;
  logic       blink;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Reference model state
  int mh, mm, ms, mmode;
  bit mblink;

  clock_mode_ctrl #(
    .INIT_HOUR (INIT_H),
    .INIT_MIN  (INIT_M)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enb      (enb),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .hour     (hour),
    .minute   (minute),
    .second   (second),
    .mode     (mode),
    .blink    (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: time as seconds-of-day, mode rules applied straight from the behaviour list.
  always @(posedge clk) begin
    int t;
    if (!rst_n) begin
      mh = INIT_H; mm = INIT_M; ms = 0; mmode = 0; mblink = 0;
    end else begin
      case (mmode)
        0: begin
          if (enb) begin
            t  = (mh * 3600 + mm * 60 + ms + 1) % 86400;
            mh = t / 3600;
            mm = (t / 60) % 60;
            ms = t % 60;
          end
          if (btn_mode) begin mmode = 1; mblink = 1; end
          else mblink = 0;
        end
        1: begin
          if (enb) mblink = !mblink;
          if (btn_mode) mmode = 2;
          else if (btn_inc) mh = (mh + 1) % 24;
        end
        default: begin
          if (btn_mode) begin mmode = 0; ms = 0; mblink = 0; end
          else begin
            if (enb) mblink = !mblink;
            if (btn_inc) mm = (mm + 1) % 60;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_hour",   int'(hour),   mh);
      chk("model_minute", int'(minute), mm);
      chk("model_second", int'(second), ms);
      chk("model_mode",   int'(mode),   mmode);
      chk("model_blink",  int'(blink),  int'(mblink));
    end
  end

  task automatic step(input bit e, input bit bm, input bit bi);
    enb = e; btn_mode = bm; btn_inc = bi;
    @(posedge clk);
    #1;
    enb = 0; btn_mode = 0; btn_inc = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0);
      step(0, 0, 0);
    end
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1);
  endtask

  task automatic expect_t(input string name, input int h, input int m, input int s,
                          input int md, input int bl);
    chk({name, "_hour"},   int'(hour),   h);
    chk({name, "_minute"}, int'(minute), m);
    chk({name, "_second"}, int'(second), s);
    chk({name, "_mode"},   int'(mode),   md);
    chk({name, "_blink"},  int'(blink),  bl);
  endtask

  initial begin
    rst_n = 0; enb = 0; btn_mode = 0; btn_inc = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_en = 1;
    rst_n = 1;
    expect_t("reset", 23, 59, 0, 0, 0);

    step(1, 0, 0);
    expect_t("first_tick", 23, 59, 1, 0, 0);
    ticks(59);
    expect_t("midnight_rollover", 0, 0, 0, 0, 0);

    incs(5);
    expect_t("run_inc_ignored", 0, 0, 0, 0, 0);
    step(0, 1, 0);
    expect_t("enter_set_hour", 0, 0, 0, 1, 1);
    step(1, 0, 0); chk("blink_seq0", int'(blink), 0); idle(1);
    step(1, 0, 0); chk("blink_seq1", int'(blink), 1); idle(1);
    step(1, 0, 0); chk("blink_seq2", int'(blink), 0); idle(1);
    expect_t("frozen_time", 0, 0, 0, 1, 0);

    incs(22);
    chk("hour_22", int'(hour), 22);
    incs(3);
    expect_t("hour_wrap", 1, 0, 0, 1, 0);
    step(0, 1, 0);
    incs(58);
    chk("minute_58", int'(minute), 58);
    incs(2);
    expect_t("minute_wrap", 1, 0, 0, 2, 0);

    step(0, 1, 0);
    ticks(37);
    step(0, 1, 0);
    step(0, 1, 0);
    expect_t("set_min_sec37", 1, 0, 37, 2, 1);
    step(0, 1, 0);
    expect_t("exit_clears_sec", 1, 0, 0, 0, 0);
    step(1, 0, 0);
    chk("resume_count", int'(second), 1);

    step(0, 1, 0);
    incs(4);
    chk("hour_5", int'(hour), 5);
    step(0, 1, 1);
    expect_t("mode_beats_inc", 5, 0, 1, 2, 1);
    step(0, 1, 0);
    step(0, 1, 0);
    incs(5);
    step(0, 1, 0);
    incs(59);
    step(0, 1, 0);
    ticks(59);
    expect_t("at_10_59_59", 10, 59, 59, 0, 0);
    step(1, 1, 0);
    expect_t("tick_and_mode", 11, 0, 0, 1, 1);

    step(0, 1, 0);
    incs(42);
    chk("minute_42", int'(minute), 42);
    rst_n = 0;
    step(0, 0, 0);
    rst_n = 1;
    expect_t("reset_mid_edit", 23, 59, 0, 0, 0);

    step(0, 1, 0);
    step(1, 0, 1);
    expect_t("tick_and_inc", 0, 59, 0, 1, 0);
    step(0, 1, 0);
    ticks(1);
    step(1, 1, 0);
    expect_t("tick_and_exit", 0, 59, 0, 0, 0);
    idle(3);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
